// File: rtl/serial_framer_pkg.sv
// Shared widths, FSM state type and bit-placement helper for serial_framer.
// PARITY_CHECK_EN adds the PAR state used for the trailing odd-parity bit.
package serial_framer_pkg;

    localparam int unsigned WORD_W = 9;
    localparam int unsigned IDX_W  = 4;

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_e;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_e;
`endif

    // Word position of the frame bit with arrival index idx.
    function automatic logic [IDX_W-1:0] bit_pos(input logic [IDX_W-1:0] idx,
                                                 input logic             lsb_first);
        return lsb_first ? idx : IDX_W'(WORD_W - 1) - idx;
    endfunction

endpackage

// File: rtl/serial_framer.sv
// Serial-to-parallel framer: sof-delimited 9-bit frames into a held output word.
// Optional feature macro PARITY_CHECK_EN: frames carry a trailing odd-parity bit.
module serial_framer
    import serial_framer_pkg::*;
#(
    parameter int LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              sof,
    input  logic              word_ready,
    input  logic              ovf_clr,
    output logic [WORD_W-1:0] word,
    output logic              word_valid,
    output logic              busy,
    output logic              overflow,
    output logic              frame_err
);

    localparam logic LSB = (LSB_FIRST != 0);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              word_valid_q, word_valid_d;
    logic              overflow_q, overflow_d;
    logic              restart, capture, last_bit, complete, load, drop;
    logic [WORD_W-1:0] frame_w;
`ifdef PARITY_CHECK_EN
    logic              par_bit, par_ok;
    logic              frame_err_q, frame_err_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // sof with bit_valid always restarts, whatever the current state.
    always_comb begin
        restart  = bit_valid && sof;
        capture  = bit_valid && !sof && (state_q == SHIFT);
        last_bit = capture && (idx_q == IDX_W'(WORD_W - 1));
`ifdef PARITY_CHECK_EN
        par_bit  = bit_valid && !sof && (state_q == PAR);
`endif
    end

    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = SHIFT;
        end else begin
            case (state_q)
                SHIFT: begin
                    if (last_bit) begin
`ifdef PARITY_CHECK_EN
                        state_d = PAR;
`else
                        state_d = IDLE;
`endif
                    end
                end
`ifdef PARITY_CHECK_EN
                PAR: begin
                    if (par_bit) state_d = IDLE;
                end
`endif
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        shreg_d = shreg_q;
        idx_d   = idx_q;
        if (restart) begin
            shreg_d = '0;
            shreg_d[bit_pos('0, LSB)] = bit_in;
            idx_d = IDX_W'(1);
        end else if (capture) begin
            shreg_d[bit_pos(idx_q, LSB)] = bit_in;
            idx_d = last_bit ? '0 : idx_q + IDX_W'(1);
        end
`ifdef PARITY_CHECK_EN
        par_ok      = ^{shreg_q, bit_in};
        complete    = par_bit && par_ok;
        frame_w     = shreg_q;
        frame_err_d = par_bit && !par_ok;
`else
        complete    = last_bit;
        frame_w     = shreg_d;
`endif
    end

    // A completed frame replaces the word only if the slot is free or being popped.
    always_comb begin
        load = complete && (!word_valid_q || word_ready);
        drop = complete && word_valid_q && !word_ready;
        word_d = load ? frame_w : word_q;
        if (load) begin
            word_valid_d = 1'b1;
        end else if (word_ready) begin
            word_valid_d = 1'b0;
        end else begin
            word_valid_d = word_valid_q;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q      <= '0;
            idx_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
            frame_err_q  <= 1'b0;
`endif
        end else begin
            shreg_q      <= shreg_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            overflow_q   <= overflow_d;
`ifdef PARITY_CHECK_EN
            frame_err_q  <= frame_err_d;
`endif
        end
    end

    always_comb begin
        busy       = (state_q != IDLE);
        word       = word_q;
        word_valid = word_valid_q;
        overflow   = overflow_q;
`ifdef PARITY_CHECK_EN
        frame_err  = frame_err_q;
`else
        frame_err  = 1'b0;
`endif
    end

endmodule

// File: tb/tb_serial_framer.sv
// Scoreboard bench for serial_framer: LSB-first and MSB-first instances share stimulus,
// a frame-level reference model queues expected words and a monitor pops them.
module tb_serial_framer;

    localparam int unsigned WW = 9;
`ifdef PARITY_CHECK_EN
    localparam int unsigned FB = 10;
`else
    localparam int unsigned FB = 9;
`endif

    logic          clk = 1'b0;
    logic          rst_n, bit_in, bit_valid, sof, word_ready, ovf_clr;
    logic [WW-1:0] word_l, word_m;
    logic          wv_l, wv_m, busy_l, busy_m, ovf_l, ovf_m, fe_l, fe_m;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [WW-1:0] lsb;
        logic [WW-1:0] msb;
    } exp_t;
    exp_t exp_q[$];
    bit   fb_q[$];
    bit   m_in_frame, m_valid, m_ovf, m_ferr;

    serial_framer #(.LSB_FIRST(1)) u_lsb (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
        .word_ready(word_ready), .ovf_clr(ovf_clr), .word(word_l), .word_valid(wv_l),
        .busy(busy_l), .overflow(ovf_l), .frame_err(fe_l)
    );

    serial_framer #(.LSB_FIRST(0)) u_msb (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
        .word_ready(word_ready), .ovf_clr(ovf_clr), .word(word_m), .word_valid(wv_m),
        .busy(busy_m), .overflow(ovf_m), .frame_err(fe_m)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        fb_q.delete();
        exp_q.delete();
        m_in_frame = 0;
        m_valid    = 0;
        m_ovf      = 0;
        m_ferr     = 0;
    endtask

    // Frame-level model: collect bits in a list, build words by positional weight.
    task automatic model_step();
        bit            done = 0;
        bit            good = 1;
        bit            drop, load;
        logic [WW-1:0] wl = '0;
        logic [WW-1:0] wm = '0;
        m_ferr = 0;
        if (bit_valid && sof) begin
            fb_q.delete();
            fb_q.push_back(bit_in);
            m_in_frame = 1;
        end else if (bit_valid && m_in_frame) begin
            fb_q.push_back(bit_in);
            if (fb_q.size() == FB) begin
                done = 1;
                m_in_frame = 0;
            end
        end
        if (done) begin
`ifdef PARITY_CHECK_EN
            begin
                int unsigned ones = 0;
                for (int unsigned k = 0; k < FB; k++) if (fb_q[k]) ones++;
                good   = (ones % 2) == 1;
                m_ferr = !good;
            end
`endif
            for (int unsigned k = 0; k < WW; k++) begin
                if (fb_q[k]) begin
                    wl = wl + (WW'(1) << k);
                    wm = wm + (WW'(1) << (WW - 1 - k));
                end
            end
        end
        drop = done && good && m_valid && !word_ready;
        load = done && good && !drop;
        if (load) begin
            exp_q.push_back('{lsb: wl, msb: wm});
            m_valid = 1;
        end else if (m_valid && word_ready) begin
            m_valid = 0;
        end
        if (drop) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
    endtask

    task automatic cyc(input logic bv, input logic b, input logic s, input logic rdy, input logic clr);
        bit_valid  = bv;
        bit_in     = b;
        sof        = s;
        word_ready = rdy;
        ovf_clr    = clr;
        @(posedge clk);
        if (rst_n) model_step();
        #2;
    endtask

    task automatic send_bits(input logic [15:0] seq, input int unsigned n, input logic with_sof,
                             input logic rdy);
        for (int unsigned i = 0; i < n; i++) cyc(1'b1, seq[i], with_sof && (i == 0), rdy, 1'b0);
    endtask

    function automatic logic [15:0] make_seq(input logic [WW-1:0] d);
        logic [15:0] s = 16'(d);
`ifdef PARITY_CHECK_EN
        s[9] = ~^d;
`endif
        return s;
    endfunction

    always @(negedge clk) begin
        check("valid_lsb", 32'(wv_l), 32'(m_valid));
        check("valid_msb", 32'(wv_m), 32'(m_valid));
        check("busy_lsb", 32'(busy_l), 32'(m_in_frame));
        check("busy_msb", 32'(busy_m), 32'(m_in_frame));
        check("ovf_lsb", 32'(ovf_l), 32'(m_ovf));
        check("ovf_msb", 32'(ovf_m), 32'(m_ovf));
        check("ferr_lsb", 32'(fe_l), 32'(m_ferr));
        check("ferr_msb", 32'(fe_m), 32'(m_ferr));
        if (wv_l) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty: word_valid=1 with no expected word at %0t", $time);
            end else begin
                check("word_lsb", 32'(word_l), 32'(exp_q[0].lsb));
                check("word_msb", 32'(word_m), 32'(exp_q[0].msb));
            end
        end
        if (m_valid && word_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned rdy_bias = 3;
        rst_n = 1; bit_in = 0; bit_valid = 0; sof = 0; word_ready = 0; ovf_clr = 0;
        model_reset();
        #1 rst_n = 0;
        #1;
        check("rst_word", 32'(word_l), 32'h0);
        check("rst_valid", 32'(wv_l), 32'h0);
        check("rst_busy", 32'(busy_l), 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1;

        // Alternating frame, LSB-first word 0x155, popped the following cycle.
        send_bits(make_seq(9'h155), FB, 1'b1, 1'b1);
        check("t155_valid", 32'(wv_l), 32'h1);
        check("t155_word", 32'(word_l), 32'h155);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t155_pop", 32'(wv_l), 32'h0);

        // Bits 1,1,0.. : MSB-first 0x180, LSB-first 0x003.
        send_bits(make_seq(9'h003), FB, 1'b1, 1'b0);
        check("t180_msb", 32'(word_m), 32'h180);
        check("t180_lsb", 32'(word_l), 32'h003);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Output blocked: second frame dropped, overflow sticky until cleared.
        send_bits(make_seq(9'h0A5), FB, 1'b1, 1'b0);
        send_bits(make_seq(9'h13C), FB, 1'b1, 1'b0);
        check("tovf_flag", 32'(ovf_l), 32'h1);
        check("tovf_word", 32'(word_l), 32'h0A5);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("tovf_clr", 32'(ovf_l), 32'h0);
        check("tovf_hold", 32'(word_l), 32'h0A5);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Resync: sof at bit 5 restarts with an all-ones frame.
        send_bits(16'h0000, 5, 1'b1, 1'b1);
        send_bits(make_seq(9'h1FF), FB, 1'b1, 1'b1);
        check("tsync_word", 32'(word_l), 32'h1FF);
        check("tsync_ovf", 32'(ovf_l), 32'h0);
        check("tsync_ferr", 32'(fe_l), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef PARITY_CHECK_EN
        send_bits(16'h01FF, FB, 1'b1, 1'b1);
        check("tpar_good_valid", 32'(wv_l), 32'h1);
        check("tpar_good_word", 32'(word_l), 32'h1FF);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_bits(16'h03FF, FB, 1'b1, 1'b1);
        check("tpar_bad_ferr", 32'(fe_l), 32'h1);
        check("tpar_bad_valid", 32'(wv_l), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("tpar_pulse_end", 32'(fe_l), 32'h0);
`endif

        // Asynchronous reset mid-frame, then sof-less bits must be ignored.
        send_bits(16'h000F, 4, 1'b1, 1'b1);
        check("trst_busy_before", 32'(busy_l), 32'h1);
        #1 rst_n = 0;
        model_reset();
        #1;
        check("trst_busy", 32'(busy_l), 32'h0);
        check("trst_valid", 32'(wv_l), 32'h0);
        check("trst_word", 32'(word_l), 32'h0);
        check("trst_ovf", 32'(ovf_l), 32'h0);
        @(posedge clk);
        #2 rst_n = 1;
        send_bits(16'h01FF, FB, 1'b0, 1'b1);
        check("trst_nosof_valid", 32'(wv_l), 32'h0);
        check("trst_nosof_busy", 32'(busy_l), 32'h0);

        for (int unsigned c = 0; c < 4000; c++) begin
            if (c % 250 == 0) rdy_bias = $urandom_range(0, 4);
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 11) == 0,
                $urandom_range(0, 3) < rdy_bias, $urandom_range(0, 24) == 0);
        end
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("drain_valid", 32'(wv_l), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
